rob_commit_ctrl: RTL and testbench

- Retire-side consumer of the ROB queue. Inspects the ROB head entry every cycle and dequeues it in program order once it is marked committed.
- On each retire it updates the retirement register file (RRF) and returns the stale physical register to the free list.
- Serialises store retirement with the load/store queue and raises the pipeline-wide flush on a head entry tagged for mispredict recovery.
- Drives RVFI retire valid/order.

---
 rtl/rob_commit_ctrl.sv | 111 +++++++++++
 tb/tb_rob_commit_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_ctrl.sv
// Retire-side ROB head consumer: in-order dequeue, RRF/free-list update,
// store serialisation with the LSQ, mispredict flush and RVFI order.
module rob_commit_ctrl #(
    parameter int PREG_W  = 6,
    parameter int ORDER_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               head_valid,
    input  logic               head_commit,
    input  logic               head_flush,
    input  logic               head_is_store,
    input  logic [4:0]         head_rd,
    input  logic [PREG_W-1:0]  head_pd,
    input  logic [PREG_W-1:0]  head_old_pd,
    input  logic [31:0]        head_pc_next,
    output logic               rob_dequeue,
    output logic               rrf_we,
    output logic [4:0]         rrf_rd,
    output logic [PREG_W-1:0]  rrf_pd,
    output logic               fl_push,
    output logic [PREG_W-1:0]  fl_pd,
    output logic               store_release,
    input  logic               store_done,
    output logic               flush,
    output logic [31:0]        flush_pc,
    output logic               rvfi_valid,
    output logic [ORDER_W-1:0] rvfi_order
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ST_WAIT = 2'd1,
        FL_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ORDER_W-1:0] order_q;
    logic               boot_q;
    logic               retire;

    // Next state and all outputs, derived from state plus the head entry
    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        rob_dequeue   = 1'b0;
        rrf_we        = 1'b0;
        rrf_rd        = '0;
        rrf_pd        = '0;
        fl_push       = 1'b0;
        fl_pd         = '0;
        store_release = 1'b0;
        flush         = 1'b0;
        flush_pc      = '0;
        rvfi_valid    = 1'b0;
        rvfi_order    = '0;
        if (!rst && !boot_q) begin
            unique case (state_q)
                RUN: begin
                    if (head_valid && head_commit) begin
                        if (head_is_store) begin
                            store_release = 1'b1;
                            state_d       = ST_WAIT;
                        end else begin
                            retire = 1'b1;
                            if (head_flush) begin
                                flush    = 1'b1;
                                flush_pc = head_pc_next;
                                state_d  = FL_WAIT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (store_done) begin
                        retire  = 1'b1;
                        state_d = RUN;
                    end
                end
                FL_WAIT: state_d = RUN;
                default: state_d = RUN;
            endcase
        end
        if (retire) begin
            rob_dequeue = 1'b1;
            rvfi_valid  = 1'b1;
            rvfi_order  = order_q;
            if (head_rd != 5'd0) begin
                rrf_we  = 1'b1;
                rrf_rd  = head_rd;
                rrf_pd  = head_pd;
                fl_push = 1'b1;
                fl_pd   = head_old_pd;
            end
        end
    end

    // State, retire counter and the post-reset quiet cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            order_q <= '0;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            boot_q  <= 1'b0;
            if (retire) order_q <= order_q + ORDER_W'(1);
        end
    end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: directed scenarios with literal expectations,
// then random traffic checked each cycle against a behavioural model.
module tb_rob_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        head_valid, head_commit, head_flush, head_is_store;
    logic [4:0]  head_rd;
    logic [5:0]  head_pd, head_old_pd;
    logic [31:0] head_pc_next;
    logic        store_done;
    logic        rob_dequeue, rrf_we, fl_push, store_release;
    logic        flush, rvfi_valid;
    logic [4:0]  rrf_rd;
    logic [5:0]  rrf_pd, fl_pd;
    logic [31:0] flush_pc;
    logic [63:0] rvfi_order;

    int checks = 0;
    int errors = 0;

    rob_commit_ctrl #(.PREG_W(6), .ORDER_W(64)) dut (
        .clk(clk), .rst(rst),
        .head_valid(head_valid), .head_commit(head_commit),
        .head_flush(head_flush), .head_is_store(head_is_store),
        .head_rd(head_rd), .head_pd(head_pd),
        .head_old_pd(head_old_pd), .head_pc_next(head_pc_next),
        .rob_dequeue(rob_dequeue), .rrf_we(rrf_we),
        .rrf_rd(rrf_rd), .rrf_pd(rrf_pd),
        .fl_push(fl_push), .fl_pd(fl_pd),
        .store_release(store_release), .store_done(store_done),
        .flush(flush), .flush_pc(flush_pc),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h @%0t", n, a, e, $time);
        end
    endtask

    // Behavioural model: remembers whether a store is outstanding,
    // whether the previous cycle raised a flush, and how many retired
    logic [63:0] m_count = '0;
    bit          m_quiet = 1'b1;
    bit          m_store = 1'b0;
    bit          m_gap   = 1'b0;

    always @(negedge clk) begin
        bit ret, rel, fl;
        ret = 0; rel = 0; fl = 0;
        if (!(rst || m_quiet || m_gap)) begin
            if (m_store) ret = store_done;
            else if (head_valid && head_commit) begin
                if (head_is_store) rel = 1;
                else begin
                    ret = 1;
                    fl  = head_flush;
                end
            end
        end
        chk("m_dequeue", rob_dequeue, ret);
        chk("m_rvfi_valid", rvfi_valid, ret);
        chk("m_order", rvfi_order, ret ? m_count : 0);
        chk("m_rrf_we", rrf_we, ret && head_rd != 0);
        chk("m_rrf_rd", rrf_rd, (ret && head_rd != 0) ? head_rd : 0);
        chk("m_rrf_pd", rrf_pd, (ret && head_rd != 0) ? head_pd : 0);
        chk("m_fl_push", fl_push, ret && head_rd != 0);
        chk("m_fl_pd", fl_pd, (ret && head_rd != 0) ? head_old_pd : 0);
        chk("m_release", store_release, rel);
        chk("m_flush", flush, fl);
        chk("m_flush_pc", flush_pc, fl ? head_pc_next : 0);
        if (rst) begin
            m_quiet = 1; m_store = 0; m_gap = 0; m_count = 0;
        end else begin
            m_quiet = 0;
            m_gap   = fl;
            if (m_store) m_store = !ret;
            else m_store = rel;
            if (ret) m_count = m_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        head_valid = 0; head_commit = 0; head_flush = 0;
        head_is_store = 0; head_rd = 0; head_pd = 0;
        head_old_pd = 0; head_pc_next = 0; store_done = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        repeat (2) tick();
        rst = 0;
        tick();
    endtask

    task automatic head(input logic [4:0] rd, input logic [5:0] pd,
                        input logic [5:0] opd);
        head_valid = 1; head_commit = 1; head_flush = 0;
        head_is_store = 0; head_rd = rd; head_pd = pd;
        head_old_pd = opd;
    endtask

    initial begin
        rst = 1;
        idle();
        @(negedge clk);
        chk("rst_dequeue", rob_dequeue, 0);
        chk("rst_order", rvfi_order, 0);
        do_reset();

        head(5, 12, 5);
        @(negedge clk);
        chk("t1_dequeue", rob_dequeue, 1);
        chk("t1_rrf_we", rrf_we, 1);
        chk("t1_rrf_rd", rrf_rd, 5);
        chk("t1_rrf_pd", rrf_pd, 12);
        chk("t1_fl_push", fl_push, 1);
        chk("t1_fl_pd", fl_pd, 5);
        chk("t1_order", rvfi_order, 0);
        tick();
        @(negedge clk);
        chk("t1_order2", rvfi_order, 1);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            head((i == 2) ? 5'd0 : 5'(i + 1), 6'(i + 20), 6'(i + 40));
            @(negedge clk);
            chk("t2_dequeue", rob_dequeue, 1);
            chk("t2_order", rvfi_order, i);
            chk("t2_rrf_we", rrf_we, i != 2);
            chk("t2_fl_push", fl_push, i != 2);
            tick();
        end

        head(7, 30, 31);
        head_is_store = 1;
        @(negedge clk);
        chk("t3_release", store_release, 1);
        chk("t3_no_deq", rob_dequeue, 0);
        tick();
        @(negedge clk);
        chk("t3_release_off", store_release, 0);
        chk("t3_wait_deq", rob_dequeue, 0);
        tick();
        tick();
        store_done = 1;
        @(negedge clk);
        chk("t3_done_deq", rob_dequeue, 1);
        chk("t3_done_order", rvfi_order, 4);
        tick();
        head_valid = 0; head_commit = 0;
        @(negedge clk);
        chk("t3_second_done", rob_dequeue, 0);
        tick();
        store_done = 0;

        head(9, 33, 34);
        head_flush = 1;
        head_pc_next = 32'h1eceb010;
        @(negedge clk);
        chk("t4_deq", rob_dequeue, 1);
        chk("t4_flush", flush, 1);
        chk("t4_flush_pc", flush_pc, 32'h1eceb010);
        tick();
        head_flush = 0;
        @(negedge clk);
        chk("t4_gap_deq", rob_dequeue, 0);
        chk("t4_gap_flush", flush, 0);
        tick();
        @(negedge clk);
        chk("t4_resume", rob_dequeue, 1);
        tick();

        head(3, 1, 2);
        head_commit = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_wait", rob_dequeue, 0);
            tick();
        end
        head_commit = 1;
        @(negedge clk);
        chk("t5_commit", rob_dequeue, 1);
        tick();

        head(4, 5, 6);
        head_is_store = 1;
        tick();
        rst = 1;
        idle();
        tick();
        rst = 0;
        tick();
        store_done = 1;
        @(negedge clk);
        chk("t6_late_done", rob_dequeue, 0);
        tick();
        store_done = 0;
        head(3, 8, 9);
        @(negedge clk);
        chk("t6_order", rvfi_order, 0);
        chk("t6_deq", rob_dequeue, 1);
        tick();

        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom % 60) == 0;
            head_valid    = ($urandom % 4) != 0;
            head_commit   = ($urandom % 3) != 0;
            head_flush    = ($urandom % 6) == 0;
            head_is_store = ($urandom % 5) == 0;
            head_rd       = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
            head_pd       = 6'($urandom);
            head_old_pd   = 6'($urandom);
            head_pc_next  = $urandom;
            store_done    = ($urandom % 3) == 0;
            tick();
        end
        rst = 0;
        idle();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
